// File: rtl/tlb_unit.sv
// Fully associative TLB: two registered search ports, a read port, tlbwr/tlbfill writes and an invtlb sweep FSM.
// Build option: define TLB_FILL_LFSR_EN to take the tlbfill index from an LFSR instead of a counter.
package tlb_unit_pkg;
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } phytran_item_t;
endpackage

module tlb_unit
    import tlb_unit_pkg::*;
#(
    parameter int TLBNUMSIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [18:0]           s0_vppn,
    input  logic                  s0_va_bit12,
    input  logic [9:0]            s0_asid,
    output logic                  s0_found,
    output logic [TLBNUMSIZE-1:0] s0_index,
    output logic [5:0]            s0_ps,
    output phytran_item_t         s0_phytran,
    input  logic                  s1e,
    input  logic [18:0]           s1_vppn,
    input  logic                  s1_va_bit12,
    input  logic [9:0]            s1_asid,
    output logic [TLBNUMSIZE-1:0] s1_index,
    output logic                  s1_ne,
    output logic [5:0]            s1_ps,
    output phytran_item_t         s1_phytran,
    input  logic                  rd_req,
    input  logic [TLBNUMSIZE-1:0] r_index,
    output logic                  re,
    output logic [5:0]            r_ps,
    output logic [9:0]            r_asid,
    output logic                  r_ne,
    output logic                  r_g,
    output logic [18:0]           r_vppn,
    output phytran_item_t         r_phytran0,
    output phytran_item_t         r_phytran1,
    input  logic                  we,
    input  logic                  fill,
    input  logic [TLBNUMSIZE-1:0] w_index,
    input  logic [5:0]            w_ps,
    input  logic                  w_ne,
    input  logic [9:0]            w_asid,
    input  logic [18:0]           w_vppn,
    input  logic                  w_g,
    input  phytran_item_t         w_phytran0,
    input  phytran_item_t         w_phytran1,
    input  logic                  inv_req,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            f_asid,
    input  logic [18:0]           f_va,
    output logic                  inv_busy
);

    localparam int N = 2 ** TLBNUMSIZE;

    typedef enum logic {IDLE, SWEEP} inv_state_t;

    typedef struct packed {
        logic                  found;
        logic [TLBNUMSIZE-1:0] idx;
        logic [5:0]            ps;
        phytran_item_t         pt;
    } lookup_t;

    logic [N-1:0]  ent_e;
    logic [N-1:0]  ent_g;
    logic [9:0]    ent_asid [N];
    logic [18:0]   ent_vppn [N];
    logic [5:0]    ent_ps   [N];
    phytran_item_t ent_p0   [N];
    phytran_item_t ent_p1   [N];

    // Page sizes other than 4 KiB / 2 MiB are stored but never translate.
    function automatic logic vppn_hit(input logic [5:0] ps, input logic [18:0] ent_va,
                                      input logic [18:0] va);
        if (ps == 6'd12)
            return ent_va == va;
        else if (ps == 6'd21)
            return ent_va[18:9] == va[18:9];
        else
            return 1'b0;
    endfunction

    // Scan from the top so the lowest matching index is the one left standing.
    function automatic lookup_t lookup(input logic [18:0] va, input logic va_bit12,
                                       input logic [9:0] asid);
        lookup_t r;
        logic    odd;
        r   = '0;
        odd = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_e[i] && (ent_g[i] || ent_asid[i] == asid) &&
                vppn_hit(ent_ps[i], ent_vppn[i], va)) begin
                odd     = (ent_ps[i] == 6'd12) ? va_bit12 : va[8];
                r.found = 1'b1;
                r.idx   = TLBNUMSIZE'(i);
                r.ps    = ent_ps[i];
                r.pt    = odd ? ent_p1[i] : ent_p0[i];
            end
        end
        return r;
    endfunction

    lookup_t s0_lkp;
    lookup_t s1_lkp;

    always_comb begin
        s0_lkp = lookup(s0_vppn, s0_va_bit12, s0_asid);
        s1_lkp = lookup(s1_vppn, s1_va_bit12, s1_asid);
    end

    // ---- search stage p1 ----
    logic                  s0_found_p1;
    logic [TLBNUMSIZE-1:0] s0_index_p1;
    logic [5:0]            s0_ps_p1;
    phytran_item_t         s0_pt_p1;
    logic                  s1_ne_p1;
    logic [TLBNUMSIZE-1:0] s1_index_p1;
    logic [5:0]            s1_ps_p1;
    phytran_item_t         s1_pt_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_found_p1 <= 1'b0;
            s0_index_p1 <= '0;
            s0_ps_p1    <= '0;
            s0_pt_p1    <= '0;
            s1_ne_p1    <= 1'b0;
            s1_index_p1 <= '0;
            s1_ps_p1    <= '0;
            s1_pt_p1    <= '0;
        end else begin
            s0_found_p1 <= s0_lkp.found;
            s0_index_p1 <= s0_lkp.idx;
            s0_ps_p1    <= s0_lkp.ps;
            s0_pt_p1    <= s0_lkp.pt;
            if (s1e) begin
                s1_ne_p1    <= ~s1_lkp.found;
                s1_index_p1 <= s1_lkp.idx;
                s1_ps_p1    <= s1_lkp.ps;
                s1_pt_p1    <= s1_lkp.pt;
            end
        end
    end

    assign s0_found   = s0_found_p1;
    assign s0_index   = s0_index_p1;
    assign s0_ps      = s0_ps_p1;
    assign s0_phytran = s0_pt_p1;
    assign s1_ne      = s1_ne_p1;
    assign s1_index   = s1_index_p1;
    assign s1_ps      = s1_ps_p1;
    assign s1_phytran = s1_pt_p1;

    // ---- read stage p1 ----
    logic          re_p1;
    logic          r_ne_p1;
    logic          r_g_p1;
    logic [5:0]    r_ps_p1;
    logic [9:0]    r_asid_p1;
    logic [18:0]   r_vppn_p1;
    phytran_item_t r_p0_p1;
    phytran_item_t r_p1_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_p1     <= 1'b0;
            r_ne_p1   <= 1'b0;
            r_g_p1    <= 1'b0;
            r_ps_p1   <= '0;
            r_asid_p1 <= '0;
            r_vppn_p1 <= '0;
            r_p0_p1   <= '0;
            r_p1_p1   <= '0;
        end else begin
            re_p1 <= rd_req;
            if (rd_req) begin
                r_ne_p1   <= ~ent_e[r_index];
                r_g_p1    <= ent_e[r_index] & ent_g[r_index];
                r_ps_p1   <= ent_e[r_index] ? ent_ps[r_index]   : '0;
                r_asid_p1 <= ent_e[r_index] ? ent_asid[r_index] : '0;
                r_vppn_p1 <= ent_e[r_index] ? ent_vppn[r_index] : '0;
                r_p0_p1   <= ent_e[r_index] ? ent_p0[r_index]   : '0;
                r_p1_p1   <= ent_e[r_index] ? ent_p1[r_index]   : '0;
            end
        end
    end

    assign re         = re_p1;
    assign r_ne       = r_ne_p1;
    assign r_g        = r_g_p1;
    assign r_ps       = r_ps_p1;
    assign r_asid     = r_asid_p1;
    assign r_vppn     = r_vppn_p1;
    assign r_phytran0 = r_p0_p1;
    assign r_phytran1 = r_p1_p1;

    // invtlb sweep control
    inv_state_t            state;
    inv_state_t            state_n;
    logic                  inv_accept;
    logic [TLBNUMSIZE-1:0] inv_ptr;
    logic [2:0]            op_q;
    logic [9:0]            f_asid_q;
    logic [18:0]           f_va_q;
    logic                  inv_hit;

    always_comb begin
        state_n    = state;
        inv_accept = 1'b0;
        case (state)
            IDLE: begin
                if (inv_req && inv_op <= 5'd6) begin
                    inv_accept = 1'b1;
                    state_n    = SWEEP;
                end
            end
            SWEEP: begin
                if (&inv_ptr)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            inv_ptr <= '0;
        end else begin
            state <= state_n;
            if (inv_accept)
                inv_ptr <= '0;
            else if (state == SWEEP)
                inv_ptr <= inv_ptr + TLBNUMSIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (inv_accept) begin
            op_q     <= inv_op[2:0];
            f_asid_q <= f_asid;
            f_va_q   <= f_va;
        end
    end

    assign inv_busy = (state == SWEEP);

    always_comb begin
        logic asid_eq;
        logic va_eq;
        asid_eq = (ent_asid[inv_ptr] == f_asid_q);
        va_eq   = vppn_hit(ent_ps[inv_ptr], ent_vppn[inv_ptr], f_va_q);
        inv_hit = 1'b0;
        case (op_q)
            3'd0, 3'd1: inv_hit = 1'b1;
            3'd2:       inv_hit = ent_g[inv_ptr];
            3'd3:       inv_hit = ~ent_g[inv_ptr];
            3'd4:       inv_hit = ~ent_g[inv_ptr] & asid_eq;
            3'd5:       inv_hit = ~ent_g[inv_ptr] & asid_eq & va_eq;
            3'd6:       inv_hit = (ent_g[inv_ptr] | asid_eq) & va_eq;
            default:    inv_hit = 1'b0;
        endcase
    end

    // Writes are only taken outside a sweep; tlbwr beats tlbfill for the port.
    logic                  idle;
    logic                  wr_en;
    logic                  fill_take;
    logic [TLBNUMSIZE-1:0] fill_idx;
    logic [TLBNUMSIZE-1:0] wr_idx;

    assign idle      = (state == IDLE);
    assign wr_en     = idle & (we | fill);
    assign fill_take = idle & fill & ~we;
    assign wr_idx    = we ? w_index : fill_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ent_e <= '0;
        else if (wr_en)
            ent_e[wr_idx] <= ~w_ne;
        else if (state == SWEEP && inv_hit)
            ent_e[inv_ptr] <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_g[wr_idx]    <= w_g;
            ent_asid[wr_idx] <= w_asid;
            ent_vppn[wr_idx] <= w_vppn;
            ent_ps[wr_idx]   <= w_ps;
            ent_p0[wr_idx]   <= w_phytran0;
            ent_p1[wr_idx]   <= w_phytran1;
        end
    end

`ifdef TLB_FILL_LFSR_EN
    // Galois feedback masks (polynomial minus the x^n term) for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h3;
            3:       return 32'h5;
            4:       return 32'h9;
            5:       return 32'h9;
            6:       return 32'h21;
            7:       return 32'h41;
            8:       return 32'h71;
            default: return 32'h9;
        endcase
    endfunction

    localparam logic [31:0]           LFSR_TAPS_FULL = lfsr_taps(TLBNUMSIZE);
    localparam logic [TLBNUMSIZE-1:0] LFSR_TAPS      = LFSR_TAPS_FULL[TLBNUMSIZE-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fill_idx <= TLBNUMSIZE'(1);
        else if (fill_take)
            fill_idx <= {fill_idx[TLBNUMSIZE-2:0], 1'b0} ^
                        (fill_idx[TLBNUMSIZE-1] ? LFSR_TAPS : '0);
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fill_idx <= '0;
        else if (fill_take)
            fill_idx <= fill_idx + TLBNUMSIZE'(1);
    end
`endif

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized self-checking bench for tlb_unit against an entry-array reference model.
module tb_tlb_unit;
    import tlb_unit_pkg::*;

    localparam int N = 16;

    logic          clk, reset;
    logic [18:0]   s0_vppn;
    logic          s0_va_bit12;
    logic [9:0]    s0_asid;
    logic          s0_found;
    logic [3:0]    s0_index;
    logic [5:0]    s0_ps;
    phytran_item_t s0_phytran;
    logic          s1e;
    logic [18:0]   s1_vppn;
    logic          s1_va_bit12;
    logic [9:0]    s1_asid;
    logic [3:0]    s1_index;
    logic          s1_ne;
    logic [5:0]    s1_ps;
    phytran_item_t s1_phytran;
    logic          rd_req;
    logic [3:0]    r_index;
    logic          re;
    logic [5:0]    r_ps;
    logic [9:0]    r_asid;
    logic          r_ne, r_g;
    logic [18:0]   r_vppn;
    phytran_item_t r_phytran0, r_phytran1;
    logic          we, fill;
    logic [3:0]    w_index;
    logic [5:0]    w_ps;
    logic          w_ne;
    logic [9:0]    w_asid;
    logic [18:0]   w_vppn;
    logic          w_g;
    phytran_item_t w_phytran0, w_phytran1;
    logic          inv_req;
    logic [4:0]    inv_op;
    logic [9:0]    f_asid;
    logic [18:0]   f_va;
    logic          inv_busy;

    tlb_unit #(.TLBNUMSIZE(4)) dut (
        .clk(clk), .reset(reset),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_ps(s0_ps), .s0_phytran(s0_phytran),
        .s1e(s1e), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_index(s1_index), .s1_ne(s1_ne), .s1_ps(s1_ps), .s1_phytran(s1_phytran),
        .rd_req(rd_req), .r_index(r_index),
        .re(re), .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g), .r_vppn(r_vppn),
        .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
        .we(we), .fill(fill), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid),
        .w_vppn(w_vppn), .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
        .inv_req(inv_req), .inv_op(inv_op), .f_asid(f_asid), .f_va(f_va),
        .inv_busy(inv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one record per entry plus a count of fills since reset.
    bit            m_e    [N];
    bit            m_g    [N];
    logic [9:0]    m_asid [N];
    logic [18:0]   m_vppn [N];
    logic [5:0]    m_ps   [N];
    phytran_item_t m_p0   [N];
    phytran_item_t m_p1   [N];
    int            m_fill_cnt;
    int            lfsr_seq [15] = '{1, 2, 4, 8, 9, 11, 15, 7, 14, 5, 10, 13, 3, 6, 12};

    function automatic int m_fill_index();
`ifdef TLB_FILL_LFSR_EN
        return lfsr_seq[m_fill_cnt % 15];
`else
        return m_fill_cnt % N;
`endif
    endfunction

    function automatic bit m_vmatch(int i, logic [18:0] va);
        if (m_ps[i] == 6'd12) return m_vppn[i] == va;
        if (m_ps[i] == 6'd21) return m_vppn[i][18:9] == va[18:9];
        return 1'b0;
    endfunction

    function automatic logic [36:0] m_lookup(logic [18:0] va, logic b12, logic [9:0] asid);
        logic odd;
        for (int i = 0; i < N; i++) begin
            if (m_e[i] && (m_g[i] || m_asid[i] == asid) && m_vmatch(i, va)) begin
                odd = (m_ps[i] == 6'd12) ? b12 : va[8];
                return {1'b1, 4'(i), m_ps[i], odd ? m_p1[i] : m_p0[i]};
            end
        end
        return '0;
    endfunction

    function automatic logic [89:0] m_read(int i);
        if (!m_e[i]) return {1'b1, 1'b1, 88'b0};
        return {1'b1, 1'b0, m_g[i], m_asid[i], m_vppn[i], m_ps[i], m_p0[i], m_p1[i]};
    endfunction

    function automatic void m_invalidate(int op, logic [9:0] asid, logic [18:0] va);
        bit hit;
        for (int i = 0; i < N; i++) begin
            case (op)
                0, 1: hit = 1'b1;
                2:    hit = m_g[i];
                3:    hit = !m_g[i];
                4:    hit = !m_g[i] && m_asid[i] == asid;
                5:    hit = !m_g[i] && m_asid[i] == asid && m_vmatch(i, va);
                6:    hit = (m_g[i] || m_asid[i] == asid) && m_vmatch(i, va);
                default: hit = 1'b0;
            endcase
            if (hit) m_e[i] = 1'b0;
        end
    endfunction

    function automatic void model_write(int i);
        m_e[i] = !w_ne; m_g[i] = w_g; m_asid[i] = w_asid; m_vppn[i] = w_vppn;
        m_ps[i] = w_ps; m_p0[i] = w_phytran0; m_p1[i] = w_phytran1;
    endfunction

    function automatic logic [18:0] rand_vppn();
        logic [1:0] lo;
        logic [9:0] hi;
        lo = 2'($urandom_range(0, 3));
        hi = ($urandom_range(0, 1) != 0) ? 10'h001 : 10'h091;
        return {hi, lo[1], 7'b0, lo[0]};
    endfunction

    function automatic logic [5:0] rand_ps();
        int r;
        r = $urandom_range(0, 9);
        return (r < 5) ? 6'd12 : (r < 9) ? 6'd21 : 6'd13;
    endfunction

    function automatic logic [9:0] rand_asid();
        return ($urandom_range(0, 1) != 0) ? 10'd5 : 10'd6;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_image(input logic [18:0] vppn, input logic [5:0] ps, input logic [9:0] asid,
                             input logic g, input logic ne, input phytran_item_t p0,
                             input phytran_item_t p1);
        w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g; w_ne = ne;
        w_phytran0 = p0; w_phytran1 = p1;
    endtask

    task automatic rand_image();
        set_image(rand_vppn(), rand_ps(), rand_asid(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 26'($urandom), 26'($urandom));
    endtask

    task automatic write_entry(input int i);
        we = 1'b1; w_index = 4'(i);
        model_write(i);
        tick();
        we = 1'b0;
    endtask

    task automatic read_entry(input int i, output logic [89:0] got);
        rd_req = 1'b1; r_index = 4'(i);
        tick();
        rd_req = 1'b0;
        got = {re, r_ne, r_g, r_asid, r_vppn, r_ps, r_phytran0, r_phytran1};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_e[i] = 1'b0;
        m_fill_cnt = 0;
    endtask

    task automatic test_reset();
        logic [89:0] got;
        reset = 1'b1;
        tick(); tick();
        total++;
        if ({s0_found, s0_index, s0_ps, s0_phytran} !== 37'b0) begin
            bad++; $display("FAIL reset_s0: got %h want 0", {s0_found, s0_index, s0_ps, s0_phytran});
        end
        total++;
        if ({s1_ne, s1_index, s1_ps, s1_phytran} !== 37'b0) begin
            bad++; $display("FAIL reset_s1: got %h want 0", {s1_ne, s1_index, s1_ps, s1_phytran});
        end
        total++;
        if ({re, r_ne, r_g, r_asid, r_vppn, r_ps, r_phytran0, r_phytran1} !== 90'b0) begin
            bad++; $display("FAIL reset_rd: got %h want 0", {re, r_ne, r_g, r_asid, r_vppn, r_ps});
        end
        total++;
        if (inv_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", inv_busy);
        end
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_e[i] = 1'b0;
        m_fill_cnt = 0;
        for (int i = 0; i < N; i++) begin
            read_entry(i, got);
            total++;
            if (got !== {1'b1, 1'b1, 88'b0}) begin
                bad++; $display("FAIL reset_entry%0d: got %h want invalid", i, got);
            end
        end
    endtask

    task automatic test_write_search();
        phytran_item_t p0, p1;
        p0 = '{ppn: 20'hABCDE, plv: 2'd0, mat: 2'd0, d: 1'b0, v: 1'b1};
        p1 = '{ppn: 20'h12345, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
        set_image(19'h00100, 6'd12, 10'd5, 1'b0, 1'b0, p0, p1);
        write_entry(3);
        s0_vppn = 19'h00100; s0_va_bit12 = 1'b0; s0_asid = 10'd5;
        tick();
        total++;
        if ({s0_found, s0_index, s0_ps, s0_phytran} !== {1'b1, 4'd3, 6'd12, p0}) begin
            bad++; $display("FAIL s0_hit: got %b/%0d/%0d/%h want 1/3/12/%h",
                            s0_found, s0_index, s0_ps, s0_phytran, p0);
        end
        s0_va_bit12 = 1'b1;
        tick();
        total++;
        if ({s0_found, s0_index, s0_ps, s0_phytran} !== {1'b1, 4'd3, 6'd12, p1}) begin
            bad++; $display("FAIL s0_odd: got %h want %h", s0_phytran, p1);
        end
        s0_asid = 10'd6;
        tick();
        total++;
        if ({s0_found, s0_index, s0_ps, s0_phytran} !== 37'b0) begin
            bad++; $display("FAIL s0_asid_miss: got %h want 0", {s0_found, s0_index, s0_ps, s0_phytran});
        end
    endtask

    task automatic test_multi_hit();
        logic [36:0] held;
        set_image(19'h2A000, 6'd21, 10'd1, 1'b1, 1'b0, 26'h1111111, 26'h2222222);
        write_entry(9);
        set_image(19'h2A000, 6'd21, 10'd2, 1'b1, 1'b0, 26'h3333333, 26'h0444444);
        write_entry(2);
        s1e = 1'b1; s1_vppn = 19'h2A1FF; s1_va_bit12 = 1'b0; s1_asid = 10'd9;
        tick();
        held = {s1_ne, s1_index, s1_ps, s1_phytran};
        total++;
        if (s1_index !== 4'd2 || s1_ne !== 1'b0 || s1_phytran !== 26'h0444444) begin
            bad++; $display("FAIL s1_lowest: got idx %0d ne %b pt %h want 2 0 0444444",
                            s1_index, s1_ne, s1_phytran);
        end
        s1e = 1'b0; s1_vppn = 19'h7FFFF;
        tick();
        total++;
        if ({s1_ne, s1_index, s1_ps, s1_phytran} !== {1'b0, 4'd2, 6'd21, 26'h0444444}) begin
            bad++; $display("FAIL s1_hold: got %h want %h", {s1_ne, s1_index, s1_ps, s1_phytran}, held);
        end
        s1e = 1'b1;
        tick();
        total++;
        if ({s1_ne, s1_index, s1_ps, s1_phytran} !== {1'b1, 36'b0}) begin
            bad++; $display("FAIL s1_miss: got %h want ne=1 rest 0", {s1_ne, s1_index, s1_ps, s1_phytran});
        end
        s1e = 1'b0;
    endtask

    task automatic test_read_vs_write();
        logic [89:0] exp, got;
        exp = m_read(3);
        rd_req = 1'b1; r_index = 4'd3;
        set_image(19'h55555, 6'd21, 10'd8, 1'b1, 1'b0, 26'h0ABCDEF, 26'h0FEDCBA);
        we = 1'b1; w_index = 4'd3;
        model_write(3);
        tick();
        we = 1'b0; rd_req = 1'b0;
        got = {re, r_ne, r_g, r_asid, r_vppn, r_ps, r_phytran0, r_phytran1};
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL read_old: got %h want %h", got, exp);
        end
        read_entry(3, got);
        total++;
        if (got !== m_read(3)) begin
            bad++; $display("FAIL read_new: got %h want %h", got, m_read(3));
        end
    endtask

    task automatic test_random();
        logic [36:0] e0, e1, l;
        logic [89:0] er, got;
        bit          rq;
        for (int c = 0; c < 300; c++) begin
            we = ($urandom_range(0, 3) == 0);
            fill = ($urandom_range(0, 7) == 0);
            w_index = 4'($urandom_range(0, 15));
            rand_image();
            s0_vppn = rand_vppn(); s0_va_bit12 = 1'($urandom_range(0, 1)); s0_asid = rand_asid();
            s1e = (c == 0) || ($urandom_range(0, 2) != 0);
            s1_vppn = rand_vppn(); s1_va_bit12 = 1'($urandom_range(0, 1)); s1_asid = rand_asid();
            rq = ($urandom_range(0, 1) != 0);
            rd_req = rq; r_index = 4'($urandom_range(0, 15));
            e0 = m_lookup(s0_vppn, s0_va_bit12, s0_asid);
            if (s1e) begin
                l  = m_lookup(s1_vppn, s1_va_bit12, s1_asid);
                e1 = {~l[36], l[35:0]};
            end
            er = m_read(r_index);
            if (we) model_write(w_index);
            else if (fill) begin
                model_write(m_fill_index());
                m_fill_cnt++;
            end
            tick();
            total++;
            if ({s0_found, s0_index, s0_ps, s0_phytran} !== e0) begin
                bad++; $display("FAIL rand_s0 c%0d: got %h want %h", c, {s0_found, s0_index, s0_ps, s0_phytran}, e0);
            end
            total++;
            if ({s1_ne, s1_index, s1_ps, s1_phytran} !== e1) begin
                bad++; $display("FAIL rand_s1 c%0d: got %h want %h", c, {s1_ne, s1_index, s1_ps, s1_phytran}, e1);
            end
            got = {re, r_ne, r_g, r_asid, r_vppn, r_ps, r_phytran0, r_phytran1};
            total++;
            if (rq && got !== er) begin
                bad++; $display("FAIL rand_rd c%0d: got %h want %h", c, got, er);
            end else if (!rq && re !== 1'b0) begin
                bad++; $display("FAIL rand_re c%0d: got %b want 0", c, re);
            end
        end
        we = 1'b0; fill = 1'b0; rd_req = 1'b0; s1e = 1'b0;
    endtask

    task automatic test_fill();
        logic [89:0] got;
        int          fi;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            set_image(19'(k + 1), 6'd12, 10'd4, 1'b0, 1'b0, 26'(k * 3), 26'(k * 5));
            fill = 1'b1;
            model_write(m_fill_index());
            m_fill_cnt++;
            tick();
        end
        fill = 1'b0;
        for (int i = 0; i < N; i++) begin
            read_entry(i, got);
            total++;
            if (got !== m_read(i)) begin
                bad++; $display("FAIL fill_entry%0d: got %h want %h", i, got, m_read(i));
            end
        end
        set_image(19'h07777, 6'd12, 10'd4, 1'b0, 1'b0, 26'h7, 26'h7);
        we = 1'b1; fill = 1'b1; w_index = 4'd7;
        model_write(7);
        tick();
        we = 1'b0;
        set_image(19'h05555, 6'd12, 10'd4, 1'b0, 1'b0, 26'h5, 26'h5);
        fi = m_fill_index();
        model_write(fi);
        m_fill_cnt++;
        tick();
        fill = 1'b0;
        read_entry(7, got);
        total++;
        if (got !== m_read(7)) begin
            bad++; $display("FAIL we_beats_fill: got %h want %h", got, m_read(7));
        end
        read_entry(fi, got);
        total++;
        if (got !== m_read(fi)) begin
            bad++; $display("FAIL fill_hold idx%0d: got %h want %h", fi, got, m_read(fi));
        end
    endtask

    task automatic test_invtlb_asid();
        logic [89:0] got;
        int          n;
        do_reset();
        set_image(19'h00200, 6'd12, 10'd3, 1'b1, 1'b0, 26'h1, 26'h2);
        write_entry(0);
        set_image(19'h00300, 6'd12, 10'd7, 1'b0, 1'b0, 26'h3, 26'h4);
        write_entry(1);
        set_image(19'h00400, 6'd12, 10'd7, 1'b1, 1'b0, 26'h5, 26'h6);
        write_entry(5);
        inv_req = 1'b1; inv_op = 5'd4; f_asid = 10'd7; f_va = 19'h0;
        tick();
        inv_req = 1'b0;
        n = 0;
        while (inv_busy === 1'b1 && n < 40) begin
            n++;
            we = (n == 3);
            w_index = 4'd5;
            w_ne = 1'b1;
            tick();
        end
        we = 1'b0;
        total++;
        if (n != 16) begin
            bad++; $display("FAIL inv4_busy_len: got %0d want 16", n);
        end
        m_invalidate(4, 10'd7, 19'h0);
        for (int i = 0; i < 6; i++) begin
            read_entry(i, got);
            total++;
            if (got !== m_read(i)) begin
                bad++; $display("FAIL inv4_entry%0d: got %h want %h", i, got, m_read(i));
            end
        end
        read_entry(1, got);
        total++;
        if (got[88] !== 1'b1) begin
            bad++; $display("FAIL inv4_idx1_ne: got %b want 1", got[88]);
        end
    endtask

    task automatic test_inv_random();
        logic [89:0] got;
        int          n, op, wi;
        logic [9:0]  fa;
        logic [18:0] fv;
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < N; i++) begin
                rand_image();
                write_entry(i);
            end
            op = r;
            fa = rand_asid();
            fv = ($urandom_range(0, 1) != 0) ? m_vppn[$urandom_range(0, 15)] : rand_vppn();
            wi = $urandom_range(0, 15);
            rand_image();
            w_ne = 1'b0;
            we = 1'b1; w_index = 4'(wi);
            model_write(wi);
            inv_req = 1'b1; inv_op = 5'(op); f_asid = fa; f_va = fv;
            tick();
            we = 1'b0; inv_req = 1'b0;
            n = 0;
            while (inv_busy === 1'b1 && n < 40) begin
                n++;
                inv_req = (n == 4);
                inv_op = 5'd0;
                f_asid = ~fa;
                tick();
            end
            inv_req = 1'b0;
            total++;
            if (n != 16) begin
                bad++; $display("FAIL invr_len op%0d: got %0d want 16", op, n);
            end
            m_invalidate(op, fa, fv);
            for (int i = 0; i < N; i++) begin
                read_entry(i, got);
                total++;
                if (got !== m_read(i)) begin
                    bad++; $display("FAIL invr op%0d entry%0d: got %h want %h", op, i, got, m_read(i));
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [89:0] got;
        int          n;
        for (int i = 0; i < 4; i++) begin
            set_image(19'(i), 6'd12, 10'd2, 1'b1, 1'b0, 26'(i), 26'(i));
            write_entry(i);
        end
        inv_req = 1'b1; inv_op = 5'd3; f_asid = 10'd0;
        tick();
        inv_req = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        total++;
        if (inv_busy !== 1'b0) begin
            bad++; $display("FAIL abort_busy: got %b want 0", inv_busy);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_e[i] = 1'b0;
        m_fill_cnt = 0;
        for (int i = 0; i < N; i++) begin
            read_entry(i, got);
            total++;
            if (got !== m_read(i)) begin
                bad++; $display("FAIL abort_entry%0d: got %h want %h", i, got, m_read(i));
            end
        end
        inv_req = 1'b1; inv_op = 5'd0;
        tick();
        inv_req = 1'b0;
        total++;
        if (inv_busy !== 1'b1) begin
            bad++; $display("FAIL post_abort_accept: got %b want 1", inv_busy);
        end
        n = 0;
        while (inv_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL post_abort_len: got %0d want 16", n);
        end
        set_image(19'h00444, 6'd12, 10'd1, 1'b0, 1'b0, 26'h44, 26'h45);
        write_entry(4);
        inv_req = 1'b1; inv_op = 5'd7;
        tick();
        inv_req = 1'b0;
        total++;
        if (inv_busy !== 1'b0) begin
            bad++; $display("FAIL op7_busy: got %b want 0", inv_busy);
        end
        inv_req = 1'b1; inv_op = 5'd31;
        tick();
        inv_req = 1'b0;
        tick();
        read_entry(4, got);
        total++;
        if (got !== m_read(4) || inv_busy !== 1'b0) begin
            bad++; $display("FAIL op_bad_ignored: got %h busy %b want %h busy 0", got, inv_busy, m_read(4));
        end
    endtask

    initial begin
        reset = 1'b1;
        s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
        s1e = 1'b0; s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
        rd_req = 1'b0; r_index = '0;
        we = 1'b0; fill = 1'b0; w_index = '0;
        set_image('0, '0, '0, 1'b0, 1'b0, '0, '0);
        inv_req = 1'b0; inv_op = '0; f_asid = '0; f_va = '0;
        m_fill_cnt = 0;
        test_reset();
        test_write_search();
        test_multi_hit();
        test_read_vs_write();
        test_random();
        test_fill();
        test_invtlb_asid();
        test_inv_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
